// File: rtl/round_robin_mux_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_mux_arbiter
//
// Four-way round-robin arbiter that also multiplexes the winner's data byte
// onto a shared output. The priority rotates from a last-winner pointer:
// requester last+1 has the highest priority and last has the lowest. A
// requester that keeps its Req high can hold the grant for at most MAX_BURST
// consecutive cycles while any other requester is waiting.
//
// Ports
//   Clock    in   single clock; all state changes on its rising edge
//   Reset_n  in   synchronous active-low reset; overrides Enable and Req
//   Enable   in   allows arbitration; when low, the next edge forces IDLE
//   Req[3:0] in   request lines, 0=A 1=B 2=C 3=D
//   A,B,C,D  in   8-bit requester data
//   Gnt[3:0] out  registered grant, one-hot in GRANT, all-zero in IDLE
//   Sel[1:0] out  registered index of the current or most recent owner
//   Y[7:0]   out  registered shared data, one cycle behind Gnt
//   Valid    out  high when Y carries granted data
//   Busy     out  high while the state is GRANT
// -----------------------------------------------------------------------------
module round_robin_mux_arbiter #(
  parameter int MAX_BURST = 4  // legal range 1..15
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Enable,
  input  logic [3:0] Req,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] C,
  input  logic [7:0] D,
  output logic [3:0] Gnt,
  output logic [1:0] Sel,
  output logic [7:0] Y,
  output logic       Valid,
  output logic       Busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;      // last winner
  logic [3:0] cnt, cnt_n;      // consecutive cycles granted to current owner
  logic [3:0] gnt_n;
  logic [1:0] sel_n;
  logic [3:0] others;          // requests excluding the current owner
  logic [1:0] winner;
  logic [7:0] mux_data;

  // Round-robin pick: scan from lowest to highest priority so the last hit
  // (offset 1 from the pointer) wins. Offset 4 is the pointer itself.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign others = (state == GRANT) ? (Req & ~(4'b0001 << Sel)) : Req;
  assign winner = pick(others, ptr);

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = Gnt;
    sel_n   = Sel;

    if (!Enable) begin
      // Pointer and Sel are kept so arbitration resumes where it stopped.
      state_n = IDLE;
      gnt_n   = 4'b0000;
      cnt_n   = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Req != 4'b0000) begin
            state_n = GRANT;
            gnt_n   = 4'b0001 << winner;
            sel_n   = winner;
            ptr_n   = winner;
            cnt_n   = 4'd1;
          end
        end
        GRANT: begin
          if (!Req[Sel] || (cnt >= MAX_CNT && others != 4'b0000)) begin
            // Owner released or burst exhausted with someone waiting:
            // hand over on this edge, or fall back to IDLE if nobody waits.
            if (others != 4'b0000) begin
              gnt_n = 4'b0001 << winner;
              sel_n = winner;
              ptr_n = winner;
              cnt_n = 4'd1;
            end else begin
              state_n = IDLE;
              gnt_n   = 4'b0000;
              cnt_n   = 4'd0;
            end
          end else if (cnt < MAX_CNT) begin
            cnt_n = cnt + 4'd1;
          end else begin
            // Sole requester at the burst limit keeps the grant; the count
            // restarts instead of wrapping.
            cnt_n = 4'd1;
          end
        end
        default: begin
          state_n = IDLE;
          gnt_n   = 4'b0000;
        end
      endcase
    end
  end

  always_comb begin
    mux_data = 8'h00;
    unique case (Sel)
      2'd0: mux_data = A;
      2'd1: mux_data = B;
      2'd2: mux_data = C;
      2'd3: mux_data = D;
      default: mux_data = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= IDLE;
      ptr   <= 2'd3;  // requester 0 wins first after reset
      cnt   <= 4'd0;
      Gnt   <= 4'b0000;
      Sel   <= 2'd0;
      Y     <= 8'h00;
      Valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      Gnt   <= gnt_n;
      Sel   <= sel_n;
      // Data path follows the registered grant, hence one cycle behind Gnt.
      Y     <= (Gnt != 4'b0000) ? mux_data : 8'h00;
      Valid <= (Gnt != 4'b0000);
    end
  end

  assign Busy = (state == GRANT);

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_round_robin_mux_arbiter
//
// Directed testbench for round_robin_mux_arbiter (MAX_BURST=4). Inputs are
// driven 1 ns after the rising edge and outputs are checked at that point,
// so every check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_round_robin_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] req;
  logic [7:0] a, b, c, d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [7:0] y;
  logic       valid;
  logic       busy;

  int n_checks = 0;
  int n_passed = 0;

  round_robin_mux_arbiter #(.MAX_BURST(4)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .Enable  (enable),
    .Req     (req),
    .A       (a),
    .B       (b),
    .C       (c),
    .D       (d),
    .Gnt     (gnt),
    .Sel     (sel),
    .Y       (y),
    .Valid   (valid),
    .Busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] dat [4];
  logic [3:0] exp_gnt;
  logic [1:0] owner;

  initial begin
    dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    a = dat[0]; b = dat[1]; c = dat[2]; d = dat[3];
    rst_n = 1'b0; enable = 1'b1; req = 4'b1111;

    // Reset overrides Enable and Req.
    tick(); tick();
    check("rst_gnt",   16'(gnt),   16'h0);
    check("rst_sel",   16'(sel),   16'h0);
    check("rst_y",     16'(y),     16'h0);
    check("rst_valid", 16'(valid), 16'h0);
    check("rst_busy",  16'(busy),  16'h0);

    // Idle with requests but Enable low stays idle.
    rst_n = 1'b1; enable = 1'b0;
    tick();
    check("idle_dis_gnt", 16'(gnt), 16'h0);

    // Full contention: 0,1,2,3,0 each held 4 cycles, no gaps; Y lags by one.
    enable = 1'b1; req = 4'b1111;
    for (int k = 0; k <= 16; k++) begin
      tick();
      owner   = 2'((k / 4) % 4);
      exp_gnt = 4'b0001 << owner;
      check($sformatf("rr_gnt%0d", k), 16'(gnt), 16'(exp_gnt));
      check($sformatf("rr_busy%0d", k), 16'(busy), 16'h1);
      if (k >= 1) begin
        owner = 2'(((k - 1) / 4) % 4);
        check($sformatf("rr_y%0d", k), 16'(y), 16'(dat[owner]));
      end
    end

    // Back to idle, then single requester 2.
    enable = 1'b0; req = 4'b0000;
    tick(); tick();
    check("dis_y", 16'(y), 16'h0);
    enable = 1'b1; req = 4'b0100;
    tick();
    check("r2_gnt",   16'(gnt),   16'h4);
    check("r2_sel",   16'(sel),   16'h2);
    check("r2_valid0",16'(valid), 16'h0);
    tick();
    check("r2_y",     16'(y),     16'h33);
    check("r2_valid", 16'(valid), 16'h1);
    req = 4'b0000;
    tick();
    check("r2_drop_gnt",  16'(gnt),  16'h0);
    check("r2_drop_busy", 16'(busy), 16'h0);
    check("r2_sel_hold",  16'(sel),  16'h2);
    tick();
    check("r2_drop_y",     16'(y),     16'h0);
    check("r2_drop_valid", 16'(valid), 16'h0);

    // Sole requester 1 for 10 cycles: no drop at the burst boundary.
    // Other data inputs change and must not reach Y.
    req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("solo_gnt%0d", k), 16'(gnt), 16'h2);
      a = 8'(8'hA0 + k); c = 8'(8'hC0 + k); d = 8'(8'hD0 + k);
      if (k >= 1) check($sformatf("solo_y%0d", k), 16'(y), 16'h22);
    end
    a = dat[0]; c = dat[2]; d = dat[3];

    // Owner 1 releases while 2 waits: handover on the same edge.
    req = 4'b0100;
    tick();
    check("ho_gnt2", 16'(gnt), 16'h4);
    req = 4'b0101;
    tick();
    check("ho_hold2", 16'(gnt), 16'h4);
    // Owner 2 drops with Req[0] high: 0100 -> 0001, Busy stays high.
    req = 4'b0001;
    tick();
    check("ho_gnt0",  16'(gnt),  16'h1);
    check("ho_busy",  16'(busy), 16'h1);
    check("ho_sel0",  16'(sel),  16'h0);

    // Owner 3, then Enable drops mid-grant.
    req = 4'b1000;
    tick();
    check("en_gnt3", 16'(gnt), 16'h8);
    check("en_sel3", 16'(sel), 16'h3);
    enable = 1'b0;
    tick();
    check("en_off_gnt",  16'(gnt),   16'h0);
    check("en_off_busy", 16'(busy),  16'h0);
    check("en_off_y44",  16'(y),     16'h44);
    tick();
    check("en_off_y",     16'(y),     16'h0);
    check("en_off_valid", 16'(valid), 16'h0);
    // Pointer preserved at 3: requester 0 wins over 3.
    enable = 1'b1; req = 4'b1001;
    tick();
    check("en_on_gnt", 16'(gnt), 16'h1);

    // Mid-grant reset: everything zero on that edge.
    req = 4'b0100;
    tick();
    check("rs_gnt2", 16'(gnt), 16'h4);
    tick();
    check("rs_valid_pre", 16'(valid), 16'h1);
    rst_n = 1'b0;
    tick();
    check("rs_gnt",   16'(gnt),   16'h0);
    check("rs_sel",   16'(sel),   16'h0);
    check("rs_y",     16'(y),     16'h0);
    check("rs_valid", 16'(valid), 16'h0);
    check("rs_busy",  16'(busy),  16'h0);
    // Pointer back at 3: lowest active index (1) wins.
    rst_n = 1'b1; req = 4'b1010;
    tick();
    check("rs_first_gnt", 16'(gnt), 16'h2);
    tick();
    check("rs_first_y", 16'(y), 16'h22);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
